// File: rtl/knn_burst_feeder.sv
// Streams one training/input sample pair to the distance calculator in bursts of
// MAX_ELEMENTS elements, then captures the returned distance and label.
module knn_burst_feeder #(
  parameter int M            = 6,
  parameter int N            = 10,
  parameter int W            = 32,
  parameter int MAX_ELEMENTS = 16,
  parameter int TYPE_W       = 2
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        start,
  input  logic [W*M*N-1:0]            training_in,
  input  logic [W*M*N-1:0]            input_in,
  input  logic [TYPE_W-1:0]           training_type_in,
  input  logic                        data_request,
  input  logic                        done_dc,
  input  logic [W-1:0]                distance_in,
  input  logic [TYPE_W-1:0]           data_type_in,
  output logic                        ready,
  output logic [W*MAX_ELEMENTS-1:0]   training_data,
  output logic [W*MAX_ELEMENTS-1:0]   input_data,
  output logic [TYPE_W-1:0]           training_data_type,
  output logic                        busy,
  output logic                        result_valid,
  output logic [W-1:0]                distance,
  output logic [TYPE_W-1:0]           data_type,
  output logic                        protocol_err
);

  localparam int TOTAL      = M * N;
  localparam int NUM_BURSTS = (TOTAL + MAX_ELEMENTS - 1) / MAX_ELEMENTS;
  localparam int BW         = $clog2(NUM_BURSTS) + 1;
  localparam int VW         = W * TOTAL;
  localparam int BUSW       = W * MAX_ELEMENTS;
  localparam logic [BW-1:0] LAST_B = BW'(NUM_BURSTS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT_REQ,
    S_WAIT_DONE,
    S_RESULT
  } state_t;

  state_t              state_q, state_d;
  logic [BW-1:0]       b_q, b_d;
  logic [VW-1:0]       tr_sh_q, tr_sh_d;
  logic [VW-1:0]       in_sh_q, in_sh_d;
  logic                ready_q, ready_d;
  logic [BUSW-1:0]     training_data_q, training_data_d;
  logic [BUSW-1:0]     input_data_q, input_data_d;
  logic [TYPE_W-1:0]   training_data_type_q, training_data_type_d;
  logic                busy_q, busy_d;
  logic                result_valid_q, result_valid_d;
  logic [W-1:0]        distance_q, distance_d;
  logic [TYPE_W-1:0]   data_type_q, data_type_d;
  logic                protocol_err_q, protocol_err_d;
  logic [BW-1:0]       b_nxt;

  // Slots past the end of the sample are zero-filled.
  function automatic logic [BUSW-1:0] burst_of(input logic [VW-1:0] vec,
                                               input logic [BW-1:0] b);
    logic [BUSW-1:0] r;
    int idx;
    r = '0;
    for (int j = 0; j < MAX_ELEMENTS; j++) begin
      idx = MAX_ELEMENTS * int'(b) + j;
      if (idx < TOTAL) r[j*W +: W] = vec[idx*W +: W];
    end
    return r;
  endfunction

  assign b_nxt = b_q + 1'b1;

  always_comb begin
    state_d              = state_q;
    b_d                  = b_q;
    tr_sh_d              = tr_sh_q;
    in_sh_d              = in_sh_q;
    training_data_d      = training_data_q;
    input_data_d         = input_data_q;
    training_data_type_d = training_data_type_q;
    distance_d           = distance_q;
    data_type_d          = data_type_q;
    protocol_err_d       = protocol_err_q;

    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          tr_sh_d              = training_in;
          in_sh_d              = input_in;
          training_data_type_d = training_type_in;
          b_d                  = '0;
          training_data_d      = burst_of(training_in, '0);
          input_data_d         = burst_of(input_in, '0);
          protocol_err_d       = 1'b0;
          state_d              = S_SEND;
        end
      end
      S_SEND: begin
        state_d = (b_q == LAST_B) ? S_WAIT_DONE : S_WAIT_REQ;
      end
      S_WAIT_REQ: begin
        // An early result aborts the stream and is flagged.
        if (done_dc) begin
          protocol_err_d = 1'b1;
          distance_d     = distance_in;
          data_type_d    = data_type_in;
          state_d        = S_RESULT;
        end else if (data_request) begin
          b_d             = b_nxt;
          training_data_d = burst_of(tr_sh_q, b_nxt);
          input_data_d    = burst_of(in_sh_q, b_nxt);
          state_d         = S_SEND;
        end
      end
      S_WAIT_DONE: begin
        if (done_dc) begin
          distance_d  = distance_in;
          data_type_d = data_type_in;
          state_d     = S_RESULT;
        end
      end
      S_RESULT: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    ready_d        = (state_d == S_SEND);
    result_valid_d = (state_d == S_RESULT);
    busy_d         = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q              <= S_IDLE;
      b_q                  <= '0;
      tr_sh_q              <= '0;
      in_sh_q              <= '0;
      ready_q              <= 1'b0;
      training_data_q      <= '0;
      input_data_q         <= '0;
      training_data_type_q <= '0;
      busy_q               <= 1'b0;
      result_valid_q       <= 1'b0;
      distance_q           <= '0;
      data_type_q          <= '0;
      protocol_err_q       <= 1'b0;
    end else begin
      state_q              <= state_d;
      b_q                  <= b_d;
      tr_sh_q              <= tr_sh_d;
      in_sh_q              <= in_sh_d;
      ready_q              <= ready_d;
      training_data_q      <= training_data_d;
      input_data_q         <= input_data_d;
      training_data_type_q <= training_data_type_d;
      busy_q               <= busy_d;
      result_valid_q       <= result_valid_d;
      distance_q           <= distance_d;
      data_type_q          <= data_type_d;
      protocol_err_q       <= protocol_err_d;
    end
  end

  assign ready              = ready_q;
  assign training_data      = training_data_q;
  assign input_data         = input_data_q;
  assign training_data_type = training_data_type_q;
  assign busy               = busy_q;
  assign result_valid       = result_valid_q;
  assign distance           = distance_q;
  assign data_type          = data_type_q;
  assign protocol_err       = protocol_err_q;

endmodule

// File: doc/knn_burst_feeder.md
Name: knn_burst_feeder

Overview:
Feeds one sample pair (training vector + input vector, M*N elements each) into distance_calculator in bursts of MAX_ELEMENTS elements, using its ready / data_request / done handshake. It then captures the returned distance and data type. Sits between the sample store / KNN controller and distance_calculator; it is the transmitter side of that calculator's burst interface.

Parameters:
M, 6, matrix rows per sample
N, 10, matrix columns per sample
W, 32, element width in bits
MAX_ELEMENTS, 16, elements per burst (bus width in elements)
TYPE_W, 2, class-label width
Derived: TOTAL=M*N; NUM_BURSTS=ceil(TOTAL/MAX_ELEMENTS); LAST_CNT=TOTAL-(NUM_BURSTS-1)*MAX_ELEMENTS

Ports:
clk  in  1  clock, rising edge
rst  in  1  synchronous active-high reset
start  in  1  request to stream one sample pair; honoured only in IDLE
training_in  in  W*M*N  full training sample; element k at [(k+1)*W-1 -: W]
input_in  in  W*M*N  full input sample, same packing
training_type_in  in  TYPE_W  label of training sample
data_request  in  1  from calculator: previous burst consumed, send next
done_dc  in  1  from calculator: distance valid
distance_in  in  W  distance from calculator
data_type_in  in  TYPE_W  label echoed by calculator
ready  out  1  burst valid, one-cycle pulse
training_data  out  W*MAX_ELEMENTS  current training burst
input_data  out  W*MAX_ELEMENTS  current input burst
training_data_type  out  TYPE_W  label, held for whole transaction
busy  out  1  high from start accept until return to IDLE
result_valid  out  1  one-cycle pulse, distance/data_type updated
distance  out  W  captured distance
data_type  out  TYPE_W  captured label
protocol_err  out  1  sticky: done_dc before final burst sent

Behaviour:
- Reset (rst high at an edge): state IDLE; all outputs 0, including buses, distance and protocol_err. Reset mid-transaction aborts at that same edge; no further ready pulses.
- All outputs are registered.
- States: IDLE, SEND, WAIT_REQ, WAIT_DONE, RESULT.
- IDLE: on start=1, capture training_in, input_in and training_type_in into shadow registers. Load burst 0 onto the buses, set burst counter b=0 and protocol_err=0, and go to SEND. The first ready is therefore visible the cycle after start.
- SEND: ready=1 for exactly this cycle. Next state is WAIT_DONE if b==NUM_BURSTS-1, else WAIT_REQ. data_request and done_dc are ignored in SEND.
- WAIT_REQ: on data_request=1, b<=b+1, load burst b+1, go to SEND. The gap between the request edge and the ready cycle is one cycle. If done_dc=1 here, set protocol_err=1, capture distance_in and data_type_in, and go to RESULT; done_dc takes priority over data_request when both are high.
- WAIT_DONE: on done_dc=1, capture distance_in and data_type_in, go to RESULT. data_request is ignored here.
- RESULT: result_valid=1 for one cycle, then IDLE. busy drops in the cycle after RESULT.
- Burst b, slot j carries element b*MAX_ELEMENTS+j when that index is < TOTAL. Otherwise the slot is 0 (last burst zero-padded, LAST_CNT valid slots).
- Buses hold their value between bursts and after the transaction until the next start. training_data_type is held from start until the next start.
- TOTAL<=MAX_ELEMENTS: NUM_BURSTS=1; a single ready pulse, then straight to WAIT_DONE.
- start while busy: ignored, no capture. start during RESULT is also ignored.
- Burst counter width is clog2(NUM_BURSTS)+1; it never wraps within a transaction.
- Zero latency to the calculator's result: captured distance appears the edge after done_dc.

Test Plan:
- Default params; training elements k=k+1, input elements 0; start -> 4 ready pulses, each released by a data_request 3 cycles after ready. Burst 0 slots 0..15 = 1..16; burst 3 slots 0..11 = 49..60, slots 12..15 = 0.
- M=2,N=4 (TOTAL=8) -> exactly one ready pulse, with slots 8..15 = 0. done_dc with distance_in=8 and data_type_in=2 -> distance=8, data_type=2, one result_valid cycle, then busy=0.
- Full transaction with done_dc and distance_in=60 asserted 5 cycles after the last ready -> result_valid high for exactly 1 cycle; distance holds 60 afterwards; protocol_err=0.
- done_dc pulsed in WAIT_REQ after burst 1 -> protocol_err=1, result_valid pulse, return to IDLE. Next start clears protocol_err to 0.
- start pulsed again during WAIT_REQ with different data -> ignored: the remaining bursts carry the original captured data, and the ready count stays 4.
- rst asserted in WAIT_REQ after burst 2 -> next cycle busy=0, ready=0, buses=0. A subsequent start streams burst 0 correctly.
